// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch handshake.
//   imem_req   : fetch request, driven by the fetch stage
//   imem_addr  : byte address of the fetch, driven by the fetch stage
//   imem_ack   : memory has valid imem_rdata this cycle
//   imem_rdata : fetched instruction, valid only with imem_ack
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [12:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Owns the PC and drives the instruction-memory
// handshake. It feeds IF/ID with the instruction and PC+4, and produces
// the IF/ID load enable (hold) and clear (IF_flush).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   stall           : hazard unit freeze of PC and IF/ID
//   redirect        : branch/jump pulse from ID, with redirect_target
//   imem            : memory handshake (master side)
//   instruc_out     : instruction to IF/ID
//   PC_plus_4_out   : pc+4 to IF/ID
//   hold            : IF/ID load enable
//   IF_flush        : IF/ID clear
module if_fetch_stage #(
    parameter logic [12:0] RESET_PC = 13'h0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [12:0]              redirect_target,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              instruc_out,
    output logic [12:0]              PC_plus_4_out,
    output logic                     hold,
    output logic                     IF_flush
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state, state_d;
    logic [12:0] pc, pc_d;
    logic [31:0] ibuf, ibuf_d;
    logic [12:0] tgt_r, tgt_d;
    logic [12:0] tgt_in;
    logic [12:0] pc_inc;

    assign tgt_in = redirect_target & ~13'd3;
    assign pc_inc = pc + 13'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            ibuf  <= '0;
            tgt_r <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            ibuf  <= ibuf_d;
            tgt_r <= tgt_d;
        end
    end

    always_comb begin
        state_d  = state;
        pc_d     = pc;
        ibuf_d   = ibuf;
        tgt_d    = tgt_r;
        hold     = 1'b0;
        IF_flush = 1'b0;
        case (state)
            IDLE: state_d = REQ;
            REQ: begin
                IF_flush = redirect;
                if (imem.imem_ack) begin
                    if (redirect) begin
                        pc_d = tgt_in;
                    end else if (stall) begin
                        ibuf_d  = imem.imem_rdata;
                        state_d = HOLD;
                    end else begin
                        hold = 1'b1;
                        pc_d = pc_inc;
                    end
                end else if (redirect) begin
                    // Request still outstanding: remember target, keep address.
                    tgt_d   = tgt_in;
                    state_d = DROP;
                end
            end
            HOLD: begin
                IF_flush = redirect;
                if (redirect) begin
                    pc_d    = tgt_in;
                    state_d = REQ;
                end else if (!stall) begin
                    hold    = 1'b1;
                    pc_d    = pc_inc;
                    state_d = REQ;
                end
            end
            DROP: begin
                IF_flush = redirect;
                if (redirect) tgt_d = tgt_in;
                if (imem.imem_ack) begin
                    pc_d    = redirect ? tgt_in : tgt_r;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem.imem_req  = (state == REQ) || (state == DROP);
    assign imem.imem_addr = pc;
    assign PC_plus_4_out  = pc_inc;
    assign instruc_out    = (state == HOLD) ? ibuf : imem.imem_rdata;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [12:0] redirect_target;
    logic [31:0] instruc_out;
    logic [12:0] PC_plus_4_out;
    logic        hold;
    logic        IF_flush;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    if_fetch_stage_if imem ();

    if_fetch_stage #(.RESET_PC(13'h0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem            (imem.master),
        .instruc_out     (instruc_out),
        .PC_plus_4_out   (PC_plus_4_out),
        .hold            (hold),
        .IF_flush        (IF_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after the falling edge, let them settle.
    task automatic drive(input logic ack, input logic [31:0] rdata, input logic st,
                         input logic rd, input logic [12:0] tgt);
        imem.imem_ack   = ack;
        imem.imem_rdata = rdata;
        stall           = st;
        redirect        = rd;
        redirect_target = tgt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One cycle of fetch handshake with expected outputs.
    task automatic cyc(input string tag, input logic ack, input logic [31:0] rdata,
                       input logic st, input logic rd, input logic [12:0] tgt,
                       input logic e_req, input logic [12:0] e_addr,
                       input logic e_hold, input logic e_flush);
        drive(ack, rdata, st, rd, tgt);
        chk({tag, ".req"},   {31'd0, imem.imem_req}, {31'd0, e_req});
        chk({tag, ".addr"},  {19'd0, imem.imem_addr}, {19'd0, e_addr});
        chk({tag, ".hold"},  {31'd0, hold},          {31'd0, e_hold});
        chk({tag, ".flush"}, {31'd0, IF_flush},      {31'd0, e_flush});
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 13'h0);
        chk("rst.req",   {31'd0, imem.imem_req}, 32'd0);
        chk("rst.hold",  {31'd0, hold}, 32'd0);
        chk("rst.flush", {31'd0, IF_flush}, 32'd0);
        chk("rst.instr", instruc_out, 32'd0);
        chk("rst.pc4",   {19'd0, PC_plus_4_out}, 32'd4);
        chk("rst.addr",  {19'd0, imem.imem_addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        // IDLE: no request, redirect ignored
        cyc("idle", 1'b0, 32'h0, 1'b0, 1'b1, 13'h0100, 1'b0, 13'h0000, 1'b0, 1'b0);

        // Zero-wait fetch at 0 and 4
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 13'h0);
        chk("z0.instr", instruc_out, 32'hA000_0000);
        chk("z0.pc4", {19'd0, PC_plus_4_out}, 32'd4);
        cyc("z0", 1'b1, 32'hA000_0000, 1'b0, 1'b0, 13'h0, 1'b1, 13'h0000, 1'b1, 1'b0);
        chk("z4.pc4", {19'd0, PC_plus_4_out}, 32'd8);
        cyc("z4", 1'b1, 32'hA000_0004, 1'b0, 1'b0, 13'h0, 1'b1, 13'h0004, 1'b1, 1'b0);

        // Stall for 3 cycles starting with the ack at pc=8
        cyc("s0", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 13'h0, 1'b1, 13'h0008, 1'b0, 1'b0);
        drive(1'b0, 32'h1111_1111, 1'b1, 1'b0, 13'h0);
        chk("s1.instr", instruc_out, 32'hDEAD_BEEF);
        cyc("s1", 1'b0, 32'h1111_1111, 1'b1, 1'b0, 13'h0, 1'b0, 13'h0008, 1'b0, 1'b0);
        cyc("s2", 1'b0, 32'h1111_1111, 1'b1, 1'b0, 13'h0, 1'b0, 13'h0008, 1'b0, 1'b0);
        drive(1'b0, 32'h1111_1111, 1'b0, 1'b0, 13'h0);
        chk("rel.instr", instruc_out, 32'hDEAD_BEEF);
        chk("rel.pc4", {19'd0, PC_plus_4_out}, 32'd12);
        cyc("rel", 1'b0, 32'h1111_1111, 1'b0, 1'b0, 13'h0, 1'b0, 13'h0008, 1'b1, 1'b0);

        // Two wait cycles at pc=12
        cyc("w0", 1'b0, 32'h0, 1'b0, 1'b0, 13'h0, 1'b1, 13'h000C, 1'b0, 1'b0);
        cyc("w1", 1'b0, 32'h0, 1'b0, 1'b0, 13'h0, 1'b1, 13'h000C, 1'b0, 1'b0);
        cyc("w2", 1'b1, 32'hA000_000C, 1'b0, 1'b0, 13'h0, 1'b1, 13'h000C, 1'b1, 1'b0);

        // Redirect to 0x40 (low bits set, must be masked) while waiting at 0x10
        cyc("r0", 1'b0, 32'h0, 1'b0, 1'b1, 13'h0043, 1'b1, 13'h0010, 1'b0, 1'b1);
        cyc("r1", 1'b0, 32'h0, 1'b0, 1'b0, 13'h0, 1'b1, 13'h0010, 1'b0, 1'b0);
        cyc("r2", 1'b1, 32'hBAD0_0010, 1'b0, 1'b0, 13'h0, 1'b1, 13'h0010, 1'b0, 1'b0);

        // Redirect + stall + ack together at 0x40, target 0x1FFC
        cyc("rs", 1'b1, 32'hA000_0040, 1'b1, 1'b1, 13'h1FFC, 1'b1, 13'h0040, 1'b0, 1'b1);
        drive(1'b1, 32'hA000_1FFC, 1'b0, 1'b0, 13'h0);
        chk("wrap.pc4", {19'd0, PC_plus_4_out}, 32'd0);
        cyc("wrap", 1'b1, 32'hA000_1FFC, 1'b0, 1'b0, 13'h0, 1'b1, 13'h1FFC, 1'b1, 1'b0);

        // Two redirects while a fetch is outstanding: latest target wins
        cyc("d0", 1'b0, 32'h0, 1'b0, 1'b1, 13'h0100, 1'b1, 13'h0000, 1'b0, 1'b1);
        cyc("d1", 1'b0, 32'h0, 1'b0, 1'b1, 13'h0200, 1'b1, 13'h0000, 1'b0, 1'b1);
        cyc("d2", 1'b1, 32'h0, 1'b0, 1'b0, 13'h0, 1'b1, 13'h0000, 1'b0, 1'b0);

        // Reset asserted while in DROP, late ack during reset and IDLE
        cyc("e0", 1'b0, 32'h0, 1'b0, 1'b1, 13'h0300, 1'b1, 13'h0200, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 13'h0);
        chk("e1.req", {31'd0, imem.imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("e1.rreq",  {31'd0, imem.imem_req}, 32'd0);
        chk("e1.raddr", {19'd0, imem.imem_addr}, 32'd0);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 13'h0);
        chk("e1.rhold", {31'd0, hold}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        cyc("e2", 1'b1, 32'h0, 1'b0, 1'b0, 13'h0, 1'b0, 13'h0000, 1'b0, 1'b0);
        cyc("e3", 1'b1, 32'hA000_0000, 1'b0, 1'b0, 13'h0, 1'b1, 13'h0000, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 13'h0);
        chk("e4.addr", {19'd0, imem.imem_addr}, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter and drives a req/ack handshake to instruction memory. It presents each fetched instruction with its PC+4 to IF/ID, and generates the IF/ID load (`hold`) and `IF_flush` controls. It absorbs load-use stalls from the hazard unit and branch/jump redirects from ID, including a redirect that arrives while a fetch is still outstanding.

## Interface
- `RESET_PC`, 13'h0000, PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: freeze PC and IF/ID.
- `redirect`  in  1  ID stage: branch taken or jump; one-cycle pulse.
- `redirect_target`  in  13  new PC; bits [1:0] ignored and forced to 0.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  13  byte address of the fetch (= `pc`).
- `imem_ack`  in  1  memory has valid `imem_rdata` this cycle; may be high in the same cycle as `imem_req`.
- `imem_rdata`  in  32  fetched instruction, valid only when `imem_ack`=1.
- `instruc_out`  out  32  instruction to IF/ID.
- `PC_plus_4_out`  out  13  PC+4 to IF/ID.
- `hold`  out  1  IF/ID load enable (1 = load).
- `IF_flush`  out  1  IF/ID clear (instruction := 0); never high together with `hold`.

## Operation
- Registers:
  - `pc` [12:0].
  - `ibuf` [31:0] (stalled instruction).
  - `tgt_r` [12:0] (pending redirect).
  - `state` ∈ {IDLE, REQ, HOLD, DROP}.
- Reset values: `state`=IDLE, `pc`=`RESET_PC`, `ibuf`=0, `tgt_r`=0.
- Output values during reset: `imem_req`=0, `hold`=0, `IF_flush`=0, `instruc_out`=0, `PC_plus_4_out`=`RESET_PC`+4.
- Combinational outputs:
  - `imem_req` = (state==REQ || state==DROP).
  - `imem_addr` = `pc`.
  - `PC_plus_4_out` = `pc`+4, 13-bit, modulo 2^13 (13'h1FFC+4 wraps to 0).
  - `instruc_out` = `ibuf` in HOLD; otherwise `imem_rdata`.
- `IF_flush` = `redirect` in REQ, HOLD and DROP; 0 in IDLE, where `redirect` is ignored.
- IDLE → REQ unconditionally on the next edge.
- REQ:
  - `imem_ack`=1 and `redirect`=1: data is discarded; `pc`←target; stay in REQ; `hold`=0.
  - `imem_ack`=1, `redirect`=0, `stall`=1: `ibuf`←`imem_rdata`; go to HOLD; `hold`=0.
  - `imem_ack`=1, `redirect`=0, `stall`=0: `hold`=1; `pc`←`pc`+4; stay in REQ.
  - `imem_ack`=0 and `redirect`=1: `tgt_r`←target; go to DROP.
  - `imem_ack`=0 and `redirect`=0: stay in REQ; `pc` unchanged.
- HOLD (no memory request):
  - `redirect`=1: `pc`←target; go to REQ.
  - `redirect`=0 and `stall`=0: `hold`=1; `pc`←`pc`+4; go to REQ.
  - otherwise: stay in HOLD.
- DROP: the outstanding request completes at the old `imem_addr`.
  - `redirect`=1: `tgt_r`←new target (latest wins), whether or not `imem_ack` is high.
  - `imem_ack`=1: data is discarded; `pc`←`tgt_r` (or the new target if `redirect` is high this cycle); go to REQ.
- Priority: `redirect` > `stall` > normal advance.
- `hold` and `IF_flush` are mutually exclusive by construction.

## Timing
- `hold` and `IF_flush` are combinational from `imem_ack`, `stall`, `redirect` and `state`. They are sampled by IF/ID on the same rising edge that updates `pc`.
- With zero-wait memory (`imem_ack` in the same cycle as `imem_req`), throughput is one instruction per cycle and fetch-to-IF/ID latency is one edge.
- With N wait cycles, each instruction takes N+1 cycles; `hold` stays 0 while waiting.
- Handshake: `imem_req` and `imem_addr` stay stable from assertion until the cycle `imem_ack`=1, including across a redirect (DROP). The address never changes mid-request.
- Redirect penalty: the instruction in IF/ID is flushed on the redirect edge. The target is requested on the following cycle, or after the pending ack when in DROP.
- Stall release: the buffered instruction loads into IF/ID on the first cycle with `stall`=0. No refetch.
- Asynchronous reset mid-operation:
  - Returns all registers to their reset values immediately; `imem_req` drops without waiting for ack.
  - A late `imem_ack` arriving in IDLE is ignored.
- First request is issued in the cycle after the first clock edge following `rst_n` deassertion.

## Test plan
- Zero-wait memory, no stalls, from reset: `imem_addr` sequence 0,4,8,12; `hold`=1 every cycle after IDLE; `PC_plus_4_out` 4,8,12,16.
- Two-wait-cycle memory (ack 3 cycles after req): `hold` pulses once per 3 cycles; `imem_addr` is held constant across the wait cycles.
- `stall`=1 for 3 cycles coinciding with ack at pc=8: `hold`=0 for 3 cycles; `imem_req`=0 in HOLD. On release, `hold`=1 with `instruc_out`=the buffered word and `PC_plus_4_out`=12; next `imem_addr`=12.
- `redirect`=1 with target 13'h0040 while waiting for ack at pc=0x10:
  - `IF_flush`=1 for one cycle and `imem_addr` stays 0x10 until ack.
  - The acked word is discarded (`hold`=0); the next request is at 0x40.
- `redirect` and `stall` both high together with ack: `IF_flush`=1, `hold`=0, next `pc`=target. Also drive target 13'h1FFC, then advance: `PC_plus_4_out`=0 (wrap).
- `rst_n` pulsed low while in DROP: `imem_req`=0 immediately; `pc`=`RESET_PC`; an ack arriving during IDLE produces no `hold`.
